time_tag_fifo: RTL and testbench
================================

# time_tag_fifo

Parametrised successor time-tag generator for the frontend event stream. It runs the coarse period timer and formats one time-tag word per period (or per N periods), and queues pending tags in a small FIFO, so that a long `stall` or back-pressure no longer merges or loses periods silently. Lost tags are counted and reported in the next emitted tag. It also supports an external sync that reloads the period count. It sits beside the event formatters, feeding the module's output arbiter through a valid/ready port.

## Interface
- `CRC_BITS`, 5: width of the framing field (all ones).
- `MODULE_ID_BITS`, 4: module ID width.
- `PERIOD_BITS`, 48: period counter width.
- `DATA_BITS`, 128: output word width.
- `COUNTER_BITS`, 17: fine counter width; one period is 2^COUNTER_BITS cycles.
- `DEPTH`, 4: tag FIFO entries, power of two, ≥2.
- `DROP_BITS`, 8: drop-counter width; requires DATA_BITS ≥ CRC_BITS+MODULE_ID_BITS+PERIOD_BITS+4+DROP_BITS.
- `DIV_BITS`, 8: decimation control width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `module_id` in MODULE_ID_BITS: inserted into every tag; sampled at enqueue.
- `tag_div` in DIV_BITS: emit a tag every tag_div+1 periods; sampled at each period boundary.
- `sync` in 1: one-cycle pulse; reloads period from `sync_period`.
- `sync_period` in PERIOD_BITS: reload value.
- `stall` in 1: masks `valid`, does not pop.
- `valid` out 1: FIFO non-empty and ~stall.
- `ready` in 1: consumer accepts head when valid.
- `tt` out DATA_BITS: formatted head entry; all zero when FIFO empty.
- `counter` out COUNTER_BITS: fine counter.
- `period` out PERIOD_BITS: current period.
- `period_done` out 1: one-cycle pulse on counter wrap.
- `level` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Tag word layout, MSB first:
  - CRC_BITS ones
  - single-event flag 0
  - module_id
  - block ID 2'b00
  - command flag 0
  - zero padding
  - drop count (DROP_BITS)
  - period (PERIOD_BITS)
- Timer:
  - `counter` increments every cycle and wraps from all-ones to 0.
  - `period_done` is high in the cycle where counter = all-ones.
  - `period` increments on that same edge, wrapping modulo 2^PERIOD_BITS.
- Decimator:
  - A div counter increments on each `period_done`.
  - On a boundary where div counter ≥ tag_div, a tag event fires and the div counter clears.
  - tag_div = 0 gives a tag on every period.
- Tag event enqueues {module_id, drop_cnt, period value after increment}, i.e. the period just starting.
- Sync:
  - Next cycle, counter = 0 and period = sync_period; the div counter clears.
  - A tag event always fires, carrying sync_period.
  - `period_done` is suppressed in the sync cycle, even if counter = all-ones; sync wins over the wrap and only one tag is generated.
- FIFO push/pop:
  - Push when a tag event occurs and (not full, or pop in the same cycle).
  - Pop on valid & ready.
  - Simultaneous push and pop when full: both occur, level unchanged.
- Drop handling:
  - A tag event while full with no pop is dropped: drop_cnt increments, saturating at 2^DROP_BITS−1.
  - On a successful push, drop_cnt is written into the entry and cleared in the same edge.
  - A drop and a push cannot coincide, since there is at most one event per cycle.
- `stall` gates only `valid`. Entries persist, and ready during stall has no effect.

## Timing
- Reset values (asynchronous, while `rst` low): counter, period, div counter, drop_cnt and level all 0; FIFO empty; `valid`, `period_done` and `tt` all 0.
- First `period_done` occurs 2^COUNTER_BITS cycles after reset release.
- Latency: tag event at edge N → `valid` high after edge N+1 (registered push), when stall is low.
- `tt` and `valid` are combinational from FIFO registers and `stall`; there is no combinational path from `ready` to `valid`.
- Head is stable while valid & ~ready.
- Reset mid-transfer discards all queued tags and the drop count.

## Structure
- Package `time_tag_pkg`: field-width constants, framing constant, and the tag-format function (module_id, drop, period → word).
- Sub-module `period_timer`: counter, period, `period_done`, sync reload. It is instantiated once.
- The top level holds the decimator, FIFO (register array with read/write pointers plus count) and drop logic.

## Test plan
- COUNTER_BITS = 4, tag_div = 0, ready = 1 → period_done every 16 cycles; tags carry periods 1, 2, 3, …; drop field 0; valid one cycle after each period_done.
- tag_div = 2 → tags only at periods 3, 6, 9.
- ready = 0 for 7 periods, DEPTH = 4 → level saturates at 4; then ready = 1 → tags 1–4 drain, and the next tag (period 8) carries drop = 3.
- sync with sync_period = 0x100, asserted in the same cycle as counter = 15 → no period_done pulse; exactly one tag, period 0x100; next tag after 16 cycles is 0x101.
- stall = 1 with a full FIFO and ready = 1 → no pops and valid = 0; release stall → pops resume in order.
- Assert rst low mid-stream with level = 3 → all outputs are 0 immediately; after release, the counter restarts at 0 and the next tag is period 1 with drop = 0.

Source files
------------

// File: rtl/time_tag_fifo_pkg.sv
// Shared field widths, framing constant, FIFO entry type and tag-word formatter
// for the time-tag generator.
package time_tag_pkg;

    localparam int CRC_BITS       = 5;
    localparam int MODULE_ID_BITS = 4;
    localparam int PERIOD_BITS    = 48;
    localparam int DATA_BITS      = 128;
    localparam int DROP_BITS      = 8;
    localparam int HDR_BITS       = CRC_BITS + 1 + MODULE_ID_BITS + 2 + 1;
    localparam int PAD_BITS       = DATA_BITS - HDR_BITS - DROP_BITS - PERIOD_BITS;

    localparam logic [CRC_BITS-1:0] CRC_FRAME = {CRC_BITS{1'b1}};

    typedef struct packed {
        logic [MODULE_ID_BITS-1:0] module_id;
        logic [DROP_BITS-1:0]      drop;
        logic [PERIOD_BITS-1:0]    period;
    } tag_entry_t;

    // Fields MSB first: framing, single-event flag, module id, block id, command flag, pad, drop, period.
    function automatic logic [DATA_BITS-1:0] format_tag(
        input logic [MODULE_ID_BITS-1:0] module_id,
        input logic [DROP_BITS-1:0]      drop,
        input logic [PERIOD_BITS-1:0]    period
    );
        return {CRC_FRAME, 1'b0, module_id, 2'b00, 1'b0, {PAD_BITS{1'b0}}, drop, period};
    endfunction

endpackage

// File: rtl/time_tag_fifo_if.sv
// Valid/ready tag stream toward the output arbiter; stall comes from the consumer side.
interface time_tag_fifo_if;
    import time_tag_pkg::*;

    logic                 valid;
    logic                 ready;
    logic                 stall;
    logic [DATA_BITS-1:0] tt;

    modport master (output valid, output tt, input ready, input stall);
    modport slave  (input valid, input tt, output ready, output stall);

endinterface

// File: rtl/time_tag_fifo_period_timer.sv
// Coarse period timer: free-running fine counter, period count and external sync reload.
module period_timer
    import time_tag_pkg::*;
#(
    parameter int COUNTER_BITS = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_srst,
    input  logic                    i_sync,
    input  logic [PERIOD_BITS-1:0]  i_sync_period,
    output logic [COUNTER_BITS-1:0] o_counter,
    output logic [PERIOD_BITS-1:0]  o_period,
    output logic                    o_period_done
);

    logic [COUNTER_BITS-1:0] r_counter;
    logic [PERIOD_BITS-1:0]  r_period;
    logic                    w_wrap;

    assign w_wrap = (r_counter == {COUNTER_BITS{1'b1}});

    // Counter/period advance; a sync takes priority over the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter <= '0;
            r_period  <= '0;
        end else if (i_srst) begin
            r_counter <= '0;
            r_period  <= '0;
        end else if (i_sync) begin
            r_counter <= '0;
            r_period  <= i_sync_period;
        end else begin
            r_counter <= r_counter + COUNTER_BITS'(1);
            if (w_wrap) begin
                r_period <= r_period + PERIOD_BITS'(1);
            end else begin
                r_period <= r_period;
            end
        end
    end

    assign o_counter     = r_counter;
    assign o_period      = r_period;
    assign o_period_done = w_wrap & ~i_sync;

endmodule

// File: rtl/time_tag_fifo.sv
// Time-tag generator: period timer, tag decimator, tag FIFO with drop accounting,
// presented to the output arbiter through a valid/ready port.
module time_tag_fifo
    import time_tag_pkg::*;
#(
    parameter int COUNTER_BITS = 17,
    parameter int DEPTH        = 4,
    parameter int DIV_BITS     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_srst,
    input  logic [MODULE_ID_BITS-1:0]   i_module_id,
    input  logic [DIV_BITS-1:0]         i_tag_div,
    input  logic                        i_sync,
    input  logic [PERIOD_BITS-1:0]      i_sync_period,
    time_tag_fifo_if.master             tt_if,
    output logic [COUNTER_BITS-1:0]     o_counter,
    output logic [PERIOD_BITS-1:0]      o_period,
    output logic                        o_period_done,
    output logic [$clog2(DEPTH):0]      o_level
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;

    logic [PERIOD_BITS-1:0] w_period;
    logic                   w_period_done;
    logic                   w_tag_event;
    logic [PERIOD_BITS-1:0] w_tag_period;
    logic                   w_empty, w_full, w_valid, w_pop, w_push, w_drop;
    tag_entry_t             w_head;

    logic [DIV_BITS-1:0]    r_div;
    logic [DROP_BITS-1:0]   r_drop_cnt;
    logic [PTR_BITS-1:0]    r_wr_ptr, r_rd_ptr;
    logic [LVL_BITS-1:0]    r_level;
    tag_entry_t             r_mem [DEPTH];

    period_timer #(.COUNTER_BITS(COUNTER_BITS)) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_srst        (i_srst),
        .i_sync        (i_sync),
        .i_sync_period (i_sync_period),
        .o_counter     (o_counter),
        .o_period      (w_period),
        .o_period_done (w_period_done)
    );

    // A tag carries the period that is just starting: the sync value or the incremented count.
    assign w_tag_event  = i_sync | (w_period_done & (r_div >= i_tag_div));
    assign w_tag_period = i_sync ? i_sync_period : (w_period + PERIOD_BITS'(1));

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_BITS'(DEPTH));
    assign w_valid = ~w_empty & ~tt_if.stall;
    assign w_pop   = w_valid & tt_if.ready;
    assign w_push  = w_tag_event & (~w_full | w_pop);
    assign w_drop  = w_tag_event & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // Decimator: counts period boundaries, clears on each fired tag and on sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (i_srst || i_sync) begin
            r_div <= '0;
        end else if (w_period_done) begin
            if (r_div >= i_tag_div) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_BITS'(1);
            end
        end else begin
            r_div <= r_div;
        end
    end

    // Lost tags accumulate (saturating) until the next successful push carries them out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (i_srst || w_push) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_BITS{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_BITS'(1);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    // Tag FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= tag_entry_t'{module_id: i_module_id, drop: r_drop_cnt, period: w_tag_period};
                r_wr_ptr        <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_BITS'(1);
                2'b01:   r_level <= r_level - LVL_BITS'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign tt_if.valid   = w_valid;
    assign tt_if.tt      = w_empty ? '0 : format_tag(w_head.module_id, w_head.drop, w_head.period);
    assign o_period      = w_period;
    assign o_period_done = w_period_done;
    assign o_level       = r_level;

endmodule

// File: tb/tb_time_tag_fifo.sv
// Randomized and directed bench for time_tag_fifo with a cycles-since-reload reference model.
module tb_time_tag_fifo;
    import time_tag_pkg::*;

    localparam int CB    = 4;
    localparam int DEPTH = 4;
    localparam int PLEN  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        srst = 1'b0;
    logic        sync = 1'b0;
    logic [3:0]  module_id = 4'h0;
    logic [7:0]  tag_div = 8'h00;
    logic [47:0] sync_period = 48'h0;
    logic [CB-1:0] counter;
    logic [47:0] period;
    logic        period_done;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    time_tag_fifo_if bus();

    time_tag_fifo #(.COUNTER_BITS(CB), .DEPTH(DEPTH), .DIV_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_srst        (srst),
        .i_module_id   (module_id),
        .i_tag_div     (tag_div),
        .i_sync        (sync),
        .i_sync_period (sync_period),
        .tt_if         (bus),
        .o_counter     (counter),
        .o_period      (period),
        .o_period_done (period_done),
        .o_level       (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  mid;
        logic [7:0]  drop;
        logic [47:0] per;
    } ref_tag_t;

    ref_tag_t    m_q[$];
    int          m_cyc;
    logic [47:0] m_base;
    int          m_div;
    int          m_drop;

    function automatic logic [127:0] exp_word(input logic [3:0] mid, input logic [7:0] d, input logic [47:0] p);
        logic [127:0] w;
        w = '0;
        w[127:123] = 5'b11111;
        w[121:118] = mid;
        w[55:48]   = d;
        w[47:0]    = p;
        return w;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_cyc  = 0;
        m_base = 48'h0;
        m_div  = 0;
        m_drop = 0;
    endtask

    // Advance the model by one clock using the current inputs, then take the edge.
    task automatic step();
        logic done, pop, full, ev;
        logic [47:0] cur, tagp;
        cur  = m_base + 48'(m_cyc / PLEN);
        done = ((m_cyc % PLEN) == PLEN - 1) && !sync;
        pop  = (m_q.size() > 0) && !bus.stall && bus.ready;
        full = (m_q.size() == DEPTH);
        ev   = 1'b0;
        tagp = 48'h0;
        if (srst) begin
            model_clear();
        end else begin
            if (sync) begin
                ev = 1'b1; tagp = sync_period; m_base = sync_period; m_cyc = 0; m_div = 0;
            end else begin
                if (done) begin
                    if (m_div >= int'(tag_div)) begin ev = 1'b1; m_div = 0; end
                    else m_div++;
                    tagp = cur + 48'd1;
                end
                m_cyc++;
            end
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (!full || pop) begin
                    m_q.push_back('{module_id, 8'(m_drop), tagp});
                    m_drop = 0;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; srst = 1'b0; sync = 1'b0; tag_div = 8'h00;
        bus.ready = 1'b0; bus.stall = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.ready = 1'b0; bus.stall = 1'b0;
        #2;
        checks++; if (counter !== 4'h0)   begin errors++; $display("FAIL reset_counter got=%0h exp=0", counter); end
        checks++; if (period !== 48'h0)   begin errors++; $display("FAIL reset_period got=%0h exp=0", period); end
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.tt !== 128'h0)  begin errors++; $display("FAIL reset_tt got=%h exp=0", bus.tt); end
        checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL reset_pdone got=%b exp=0", period_done); end
    endtask

    task automatic test_every_period();
        int ntag = 0;
        do_reset();
        module_id = 4'hA; bus.ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            checks++;
            if (period_done !== ((n % PLEN) == PLEN - 1)) begin
                errors++; $display("FAIL every_pdone n=%0d got=%b", n, period_done);
            end
            checks++;
            if (bus.valid !== (n >= PLEN && (n % PLEN) == 0)) begin
                errors++; $display("FAIL every_valid n=%0d got=%b", n, bus.valid);
            end
            if (bus.valid === 1'b1) begin
                ntag++;
                checks++;
                if (bus.tt !== exp_word(4'hA, 8'd0, 48'(ntag))) begin
                    errors++; $display("FAIL every_tt got=%h exp=%h", bus.tt, exp_word(4'hA, 8'd0, 48'(ntag)));
                end
            end
            step();
        end
        checks++; if (ntag !== 3) begin errors++; $display("FAIL every_count got=%0d exp=3", ntag); end
    endtask

    task automatic test_decimate();
        logic [127:0] got[$];
        do_reset();
        module_id = 4'h3; tag_div = 8'd2; bus.ready = 1'b1;
        for (int n = 0; n < 10 * PLEN; n++) begin
            if (bus.valid === 1'b1) got.push_back(bus.tt);
            step();
        end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL decim_count got=%0d exp=3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_word(4'h3, 8'd0, 48'(3 * (k + 1)))) begin
                errors++; $display("FAIL decim_tt k=%0d got=%h exp=%h", k, got[k], exp_word(4'h3, 8'd0, 48'(3 * (k + 1))));
            end
        end
        tag_div = 8'd0;
    endtask

    task automatic test_overflow();
        logic [127:0] got[$];
        logic [127:0] exp[5];
        int maxlvl = 0;
        do_reset();
        module_id = 4'h5;
        for (int n = 0; n < 7 * PLEN + 1; n++) begin
            if (int'(level) > maxlvl) maxlvl = int'(level);
            step();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (maxlvl > 4) begin errors++; $display("FAIL ovf_maxlevel got=%0d exp<=4", maxlvl); end
        bus.ready = 1'b1;
        for (int n = 0; n < 40 && got.size() < 5; n++) begin
            if (bus.valid === 1'b1) got.push_back(bus.tt);
            step();
        end
        for (int k = 0; k < 4; k++) exp[k] = exp_word(4'h5, 8'd0, 48'(k + 1));
        exp[4] = exp_word(4'h5, 8'd3, 48'd8);
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL ovf_count got=%0d exp=5", got.size()); end
        for (int k = 0; k < got.size() && k < 5; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin errors++; $display("FAIL ovf_tt k=%0d got=%h exp=%h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_sync();
        logic [127:0] got[$];
        do_reset();
        module_id = 4'h7; bus.ready = 1'b1;
        for (int n = 0; n < PLEN - 1; n++) step();
        sync = 1'b1; sync_period = 48'h100;
        #1;
        checks++; if (counter !== 4'hF) begin errors++; $display("FAIL sync_precnt got=%0h exp=f", counter); end
        checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL sync_pdone got=%b exp=0", period_done); end
        step();
        sync = 1'b0;
        checks++; if (counter !== 4'h0) begin errors++; $display("FAIL sync_counter got=%0h exp=0", counter); end
        checks++; if (period !== 48'h100) begin errors++; $display("FAIL sync_period got=%0h exp=100", period); end
        for (int k = 0; k < 18; k++) begin
            if (bus.valid === 1'b1) got.push_back(bus.tt);
            step();
        end
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL sync_count got=%0d exp=2", got.size()); end
        if (got.size() >= 2) begin
            checks++; if (got[0] !== exp_word(4'h7, 8'd0, 48'h100)) begin errors++; $display("FAIL sync_tt0 got=%h", got[0]); end
            checks++; if (got[1] !== exp_word(4'h7, 8'd0, 48'h101)) begin errors++; $display("FAIL sync_tt1 got=%h", got[1]); end
        end
    endtask

    task automatic test_stall();
        logic [127:0] got[$];
        do_reset();
        module_id = 4'h9;
        for (int n = 0; n < 4 * PLEN + 1; n++) step();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL stall_fill got=%0d exp=4", level); end
        bus.stall = 1'b1; bus.ready = 1'b1;
        #1;
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (bus.valid !== 1'b0 || level !== 3'd4) begin
                errors++; $display("FAIL stall_hold n=%0d valid=%b level=%0d exp valid=0 level=4", n, bus.valid, level);
            end
            step();
        end
        bus.stall = 1'b0;
        #1;
        for (int n = 0; n < 10 && got.size() < 4; n++) begin
            if (bus.valid === 1'b1) got.push_back(bus.tt);
            step();
        end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", got.size()); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            checks++;
            if (got[k] !== exp_word(4'h9, 8'd0, 48'(k + 1))) begin errors++; $display("FAIL stall_tt k=%0d got=%h", k, got[k]); end
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        module_id = 4'hC;
        for (int n = 0; n < 2 * PLEN + 1; n++) step();
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL srst_fill got=%0d exp=2", level); end
        srst = 1'b1;
        step();
        srst = 1'b0;
        checks++;
        if (level !== 3'd0 || counter !== 4'h0 || period !== 48'h0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL srst_clear level=%0d counter=%0h period=%0h valid=%b exp all 0", level, counter, period, bus.valid);
        end
        for (int n = 0; n < PLEN; n++) step();
        checks++; if (bus.tt !== exp_word(4'hC, 8'd0, 48'd1)) begin errors++; $display("FAIL srst_tt got=%h", bus.tt); end
    endtask

    task automatic test_reset_mid();
        int ntag = 0;
        do_reset();
        module_id = 4'h2;
        for (int n = 0; n < 3 * PLEN + 1; n++) step();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_fill got=%0d exp=3", level); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (counter !== 4'h0 || period !== 48'h0 || level !== 3'd0 || bus.valid !== 1'b0 || bus.tt !== 128'h0 || period_done !== 1'b0) begin
            errors++; $display("FAIL rmid_zero counter=%0h period=%0h level=%0d valid=%b tt=%h", counter, period, level, bus.valid, bus.tt);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1; bus.ready = 1'b1;
        for (int n = 0; n < PLEN + 2; n++) begin
            if (n == 1) begin
                checks++; if (counter !== 4'h1) begin errors++; $display("FAIL rmid_counter got=%0h exp=1", counter); end
            end
            if (bus.valid === 1'b1) begin
                ntag++;
                checks++;
                if (bus.tt !== exp_word(4'h2, 8'd0, 48'd1)) begin errors++; $display("FAIL rmid_tt got=%h", bus.tt); end
            end
            step();
        end
        checks++; if (ntag !== 1) begin errors++; $display("FAIL rmid_count got=%0d exp=1", ntag); end
    endtask

    task automatic test_random();
        logic [127:0] etw;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bus.ready   = ($urandom_range(0, 3) != 0);
            bus.stall   = ($urandom_range(0, 7) == 0);
            module_id   = 4'($urandom_range(0, 15));
            tag_div     = 8'($urandom_range(0, 2));
            sync        = ($urandom_range(0, 96) == 0);
            sync_period[47:32] = 16'($urandom());
            sync_period[31:0]  = $urandom();
            srst        = ($urandom_range(0, 499) == 0);
            #1;
            etw = (m_q.size() > 0) ? exp_word(m_q[0].mid, m_q[0].drop, m_q[0].per) : 128'h0;
            checks++;
            if (counter !== CB'(m_cyc % PLEN) || period !== (m_base + 48'(m_cyc / PLEN))) begin
                errors++; $display("FAIL rnd_timer n=%0d counter=%0h period=%0h exp %0h/%0h", n, counter, period, m_cyc % PLEN, m_base + 48'(m_cyc / PLEN));
            end
            checks++;
            if (period_done !== (((m_cyc % PLEN) == PLEN - 1) && !sync)) begin
                errors++; $display("FAIL rnd_pdone n=%0d got=%b", n, period_done);
            end
            checks++;
            if (int'(level) != m_q.size() || bus.valid !== ((m_q.size() > 0) && !bus.stall)) begin
                errors++; $display("FAIL rnd_fifo n=%0d level=%0d valid=%b exp level=%0d", n, level, bus.valid, m_q.size());
            end
            checks++;
            if (bus.tt !== etw) begin errors++; $display("FAIL rnd_tt n=%0d got=%h exp=%h", n, bus.tt, etw); end
            step();
        end
        sync = 1'b0; srst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_every_period();
        test_decimate();
        test_overflow();
        test_sync();
        test_stall();
        test_soft_reset();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
